vdot_exec_unit: RTL

//  Multi-cycle execute-stage unit for the custom VDOT instruction (opcode 7'b0101011).

---
 rtl/vdot_exec_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/vdot_exec_unit.sv
// rtl/vdot_exec_unit.sv - multi-cycle VDOT execute unit, one lane product accumulated per cycle
module vdot_exec_unit #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = 2 * LANE_W + 2;

  if (LANES * LANE_W != 32) begin : g_bad_packing
    $error("vdot_exec_unit: LANES*LANE_W must equal 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        a_q, b_q, acc;
  logic               sgn_q;
  logic [IDX_W-1:0]   idx;
  logic               accept, last_lane;
  logic [LANE_W-1:0]  lane_a, lane_b;
  logic signed [LANE_W:0] a_ext, b_ext;
  logic signed [PW-1:0]   a_w, b_w, prod;
  logic [31:0]        term, acc_nxt;

  assign accept    = start & !flush & (state != S_RUN);
  assign last_lane = (idx == IDX_W'(LANES - 1));

  // One extra bit per lane lets a single signed multiplier serve both modes.
  assign lane_a  = a_q[idx*LANE_W +: LANE_W];
  assign lane_b  = b_q[idx*LANE_W +: LANE_W];
  assign a_ext   = {sgn_q & lane_a[LANE_W-1], lane_a};
  assign b_ext   = {sgn_q & lane_b[LANE_W-1], lane_b};
  assign a_w     = PW'(a_ext);
  assign b_w     = PW'(b_ext);
  assign prod    = a_w * b_w;
  assign term    = 32'(prod);
  assign acc_nxt = acc + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_RUN;
        S_RUN:   if (last_lane) state_nxt = S_DONE;
        S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = accept | (state == S_RUN);
    busy  = (state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Abort: leave result untouched, FSM returns to IDLE.
      end else if (accept) begin
        a_q   <= op_a;
        b_q   <= op_b;
        sgn_q <= is_signed;
        idx   <= '0;
        acc   <= '0;
      end else if (state == S_RUN) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
        if (last_lane) begin
          result <= acc_nxt;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule
